// File: rtl/alu_operand_loader_pkg.sv
// ============================================================================
// alu_loader_pkg : shared types and helpers for the ALU operand loader
// Revision: 1.0
// ============================================================================
`default_nettype none

package alu_loader_pkg;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    READY   = 1'b1
  } state_t;

  localparam logic MODE_SEQ = 1'b0;
  localparam logic MODE_DIR = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // The opcode always occupies the slot just past the last operand.
  function automatic int opcode_slot(input int num_operands);
    return num_operands;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_operand_loader_btn_conditioner.sv
// ============================================================================
// btn_conditioner : 2-flop synchroniser, optional debounce, rising-edge pulse
// Optional macro: ALU_LOADER_DEBOUNCE_EN      Revision: 1.0
// ============================================================================
`default_nettype none

module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic level;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= i_btn;
      sync2_q <= sync1_q;
      prev_q  <= level;
    end
  end

`ifdef ALU_LOADER_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1) + 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             stable_q;
  logic             stable_d;

  // Count consecutive cycles of disagreement; any agreement restarts the count.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign level = stable_q;
`else
  logic unused_debounce;
  assign unused_debounce = ^DEBOUNCE_CYCLES;
  assign level           = sync2_q;
`endif

  assign o_pulse = level & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/alu_operand_loader.sv
// ============================================================================
// alu_operand_loader : captures N operands plus an opcode from the switch bank
// Optional macro: ALU_LOADER_DEBOUNCE_EN      Revision: 1.0
// ============================================================================
`default_nettype none

module alu_operand_loader
  import alu_loader_pkg::*;
#(
  parameter int DATA_SIZE       = 8,
  parameter int OPCODE_SIZE     = 6,
  parameter int NUM_OPERANDS    = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SEL_W           = clog2(NUM_OPERANDS + 1)
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic [DATA_SIZE-1:0]              i_sw,
  input  logic                              i_btn_load,
  input  logic                              i_btn_clear,
  input  logic                              i_mode,
  input  logic [SEL_W-1:0]                  i_sel,
  output logic [NUM_OPERANDS*DATA_SIZE-1:0] o_operands,
  output logic [OPCODE_SIZE-1:0]            o_opcode,
  output logic [SEL_W-1:0]                  o_slot,
  output logic                              o_valid,
  output logic                              o_ready,
  output logic                              o_err
);

  localparam int               OPS_W    = NUM_OPERANDS * DATA_SIZE;
  localparam int               MASK_W   = NUM_OPERANDS + 1;
  localparam logic [SEL_W-1:0] OPC_SLOT = SEL_W'(opcode_slot(NUM_OPERANDS));

  logic load_pulse;
  logic clear_pulse;

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_cond (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_btn   (i_btn_load),
    .o_pulse (load_pulse)
  );

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_cond (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_btn   (i_btn_clear),
    .o_pulse (clear_pulse)
  );

  state_t            state_q, state_d;
  logic [OPS_W-1:0]  ops_q, ops_d;
  logic [OPCODE_SIZE-1:0] opc_q, opc_d;
  logic [SEL_W-1:0]  slot_q, slot_d;
  logic [MASK_W-1:0] mask_q, mask_d;
  logic              valid_q, valid_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              mode_q, mode_d;

  logic              wr_en;
  logic [SEL_W-1:0]  wr_slot;
  logic              mode_chg;

  assign mode_chg = (i_mode != mode_q);

  always_comb begin
    state_d = state_q;
    ops_d   = ops_q;
    opc_d   = opc_q;
    slot_d  = slot_q;
    mask_d  = mask_q;
    valid_d = valid_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    mode_d  = i_mode;
    wr_en   = 1'b0;
    wr_slot = '0;

    if (clear_pulse) begin
      state_d = COLLECT;
      ops_d   = '0;
      opc_d   = '0;
      slot_d  = '0;
      mask_d  = '0;
      valid_d = 1'b0;
    end else if (mode_chg) begin
      // Data survives a mode switch; only frame bookkeeping restarts.
      state_d = COLLECT;
      slot_d  = '0;
      mask_d  = '0;
      valid_d = 1'b0;
    end else if (load_pulse) begin
      if (mode_q == MODE_SEQ) begin
        wr_en = 1'b1;
        if (state_q == READY) begin
          wr_slot = '0;
          slot_d  = SEL_W'(1);
          valid_d = 1'b0;
          state_d = COLLECT;
        end else if (slot_q == OPC_SLOT) begin
          wr_slot = slot_q;
          slot_d  = '0;
          valid_d = 1'b1;
          ready_d = 1'b1;
          state_d = READY;
        end else begin
          wr_slot = slot_q;
          slot_d  = slot_q + SEL_W'(1);
        end
      end else begin
        state_d = COLLECT;
        if (i_sel <= OPC_SLOT) begin
          wr_en   = 1'b1;
          wr_slot = i_sel;
          mask_d  = mask_q | (MASK_W'(1) << i_sel);
          valid_d = &mask_d;
          ready_d = valid_d & ~valid_q;
        end else begin
          err_d = 1'b1;
        end
      end
    end

    if (wr_en) begin
      if (wr_slot == OPC_SLOT) begin
        opc_d = i_sw[OPCODE_SIZE-1:0];
      end
      for (int k = 0; k < NUM_OPERANDS; k++) begin
        if (wr_slot == SEL_W'(k)) ops_d[k*DATA_SIZE +: DATA_SIZE] = i_sw;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= COLLECT;
      ops_q   <= '0;
      opc_q   <= '0;
      slot_q  <= '0;
      mask_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      mode_q  <= MODE_SEQ;
    end else begin
      state_q <= state_d;
      ops_q   <= ops_d;
      opc_q   <= opc_d;
      slot_q  <= slot_d;
      mask_q  <= mask_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      mode_q  <= mode_d;
    end
  end

  assign o_operands = ops_q;
  assign o_opcode   = opc_q;
  assign o_slot     = slot_q;
  assign o_valid    = valid_q;
  assign o_ready    = ready_q;
  assign o_err      = err_q;

endmodule

`default_nettype wire

// File: doc/alu_operand_loader.md
Name: alu_operand_loader

Overview:
- Parametrised successor to the board-level operand latch that feeds the ALU. Captures N operands plus one opcode from the switch bank.
- Button inputs are synchronised and edge-detected; one press is exactly one load.
- Two load modes: sequential (one button walks through the slots) and direct (a selector chooses the slot).
- Flags a complete operand set with a valid level and a one-cycle ready strobe. Sits between the board I/O and the ALU.

Parameters:
- DATA_SIZE, 8, width of i_sw and of each operand.
- OPCODE_SIZE, 6, opcode width; must satisfy OPCODE_SIZE <= DATA_SIZE.
- NUM_OPERANDS, 2, number of operand slots; minimum 1.
- DEBOUNCE_CYCLES, 16, stable-level cycle count; used only with ALU_LOADER_DEBOUNCE_EN.
- SEL_W, derived as clog2(NUM_OPERANDS+1), width of the slot index.

Ports:
- i_clk, input, 1, system clock; all state on rising edge.
- i_rst_n, input, 1, asynchronous active-low reset.
- i_sw, input, DATA_SIZE, switch bank data.
- i_btn_load, input, 1, raw load button (asynchronous).
- i_btn_clear, input, 1, raw clear button (asynchronous).
- i_mode, input, 1, 0 = sequential, 1 = direct.
- i_sel, input, SEL_W, direct-mode slot: 0..NUM_OPERANDS-1 = operand, NUM_OPERANDS = opcode.
- o_operands, output, NUM_OPERANDS*DATA_SIZE, flattened operands; slot k at bits [k*DATA_SIZE +: DATA_SIZE].
- o_opcode, output, OPCODE_SIZE, latched opcode.
- o_slot, output, SEL_W, next slot to be written in sequential mode.
- o_valid, output, 1, complete set held.
- o_ready, output, 1, one-cycle pulse on the cycle o_valid rises.
- o_err, output, 1, one-cycle pulse on an out-of-range direct load.

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - all operands, o_opcode, o_slot and the loaded mask go to 0;
  - o_valid, o_ready and o_err go to 0;
  - synchroniser and edge-detector flops go to 0;
  - FSM goes to COLLECT.
- Reset release is synchronous to i_clk. Reset mid-frame discards the partial frame.
- Button conditioning: 2-flop synchroniser, then a rising-edge detector. A button rising before edge k produces a write at edge k+2. Held buttons never repeat. Clear uses the same path.
- Clear pulse: synchronous, and has priority over a same-cycle load. Effect is identical to reset except that the mode register is not reset.
- Opcode slot write stores i_sw[OPCODE_SIZE-1:0]; operand write stores all of i_sw.
- Sequential mode FSM, states COLLECT and READY:
  - COLLECT, load pulse: write slot o_slot, then increment o_slot. Writing slot NUM_OPERANDS (the opcode) moves to READY, sets o_valid and pulses o_ready, and o_slot wraps to 0.
  - READY, load pulse: write slot 0, o_slot=1, o_valid=0, return to COLLECT. Other slots keep their old values.
  - With NUM_OPERANDS=1 the frame is operand then opcode.
- Direct mode:
  - Load pulse with i_sel <= NUM_OPERANDS writes that slot and sets its mask bit. Reloading a slot overwrites it.
  - o_valid = all NUM_OPERANDS+1 mask bits set. o_ready pulses on the cycle valid rises, once per rise.
  - i_sel > NUM_OPERANDS: no write, o_err pulses for 1 cycle.
  - The FSM is held in COLLECT.
- Mode change (i_mode registered; change detected as a level difference):
  - o_slot=0, mask=0, o_valid=0, FSM to COLLECT;
  - data registers retained;
  - a load pulse in the same cycle is ignored.
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro ALU_LOADER_DEBOUNCE_EN.
- Defined: a debounce counter is inserted after each synchroniser. The conditioned level changes only after the synced level has differed from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count. Load latency becomes 2 + DEBOUNCE_CYCLES + 1 edges.
- Undefined: no counter; latency is 2 edges and DEBOUNCE_CYCLES is unused.

Decomposition:
- Package alu_loader_pkg holds:
  - state enum {COLLECT, READY};
  - a clog2 helper for SEL_W;
  - the opcode-slot convention (index NUM_OPERANDS);
  - mode encodings MODE_SEQ=0 and MODE_DIR=1.
- Sub-module btn_conditioner holds the synchroniser, optional debounce and edge detector, with 1 pulse output. It is instantiated twice (load, clear).

Test Plan:
- Reset, then sequential loads with sw=0x12, 0x34, 0x05 (N=2) → o_operands=0x3412, o_opcode=0x05, o_valid=1, o_ready high exactly 1 cycle, o_slot=0.
- Hold i_btn_load high for 50 cycles → exactly one write; rise to write = 2 edges (no macro).
- Direct mode: sel=2 sw=0x3F, sel=0 sw=0xAA, sel=1 sw=0x55 → valid rises only after the third load, operands=0x55AA, opcode=0x3F; then sel=3 → o_err 1-cycle pulse, no data change.
- In READY, load sw=0x77 → slot0=0x77, slot1 unchanged, o_valid=0, o_slot=1.
- Clear and load in the same cycle → all zero, o_valid=0. Separately, assert i_rst_n low mid-frame (after 1 load) → immediate zeros, no wait for a clock edge.
- With ALU_LOADER_DEBOUNCE_EN and DEBOUNCE_CYCLES=4: glitch of 3 cycles → no write; stable press → write at edge 2+4+1.
